// File: rtl/range_pkg.sv
// Shared types and defaults for the range_sequencer slice: FSM state encoding
// and the sample/counter widths that must line up with RangeFinder.
package range_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SINGLE,
        FIN,
        WAIT
    } seq_state_t;

endpackage

// File: rtl/range_sequencer_if.sv
// Bundles the sample stream (valid/ready/last) and the result slot handshake
// seen by range_sequencer; the producer/consumer side uses the master modport.
interface range_sequencer_if #(
    parameter int WIDTH = range_pkg::WIDTH_DEFAULT,
    parameter int CNT_W = range_pkg::CNT_W_DEFAULT
);

    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;

    logic [WIDTH-1:0] res_range;
    logic [CNT_W-1:0] res_count;
    logic             res_sat;
    logic             res_error;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output s_data, s_valid, s_last, res_ready,
        input  s_ready, res_range, res_count, res_sat, res_error, res_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, res_ready,
        output s_ready, res_range, res_count, res_sat, res_error, res_valid
    );

endinterface

// File: rtl/range_result_reg.sv
// One-entry valid/ready result slot holding range, beat count, saturation and
// error status of the most recently completed packet.
module range_result_reg
    import range_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] cap_range,
    input  logic [CNT_W-1:0] cap_count,
    input  logic             cap_sat,
    input  logic             cap_error,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_range,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat,
    output logic             res_error,
    output logic             res_valid
);

    // A capture in the same cycle as a drain wins, so the slot stays full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_range <= '0;
            res_count <= '0;
            res_sat   <= 1'b0;
            res_error <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_range <= cap_range;
            res_count <= cap_count;
            res_sat   <= cap_sat;
            res_error <= cap_error;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/range_sequencer.sv
// Converts each packet of the sample stream into a legal go/data/finish
// sequence for RangeFinder and captures the outcome into a result slot.
module range_sequencer
    import range_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    range_sequencer_if.slave bus,
    output logic [WIDTH-1:0] rf_data_in,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_debug_error
);

    localparam logic [CNT_W-1:0] COUNT_MAX = '1;
    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             s_ready;
    logic             accept;
    logic             capture;
    logic [CNT_W-1:0] beat_count;
    logic             count_sat;
    logic             err_seen;
    logic             cap_error;

    assign accept      = bus.s_valid && s_ready;
    assign bus.s_ready = s_ready;
    assign cap_error   = err_seen || rf_debug_error;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bus.s_last ? SINGLE : RUN;
            RUN:     if (accept && bus.s_last) state_next = FIN;
            SINGLE:  state_next = FIN;
            FIN:     state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new packet may only start while the slot is empty or draining now.
    always_comb begin
        s_ready = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE:    s_ready = !bus.res_valid || bus.res_ready;
            RUN:     s_ready = 1'b1;
            WAIT:    capture = 1'b1;
            default: s_ready = 1'b0;
        endcase
        if (reset) begin
            s_ready = 1'b0;
        end
    end

    // Finish for a one-beat packet comes from SINGLE, a cycle after go.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_go      <= 1'b0;
            rf_finish  <= 1'b0;
            rf_data_in <= '0;
        end else begin
            rf_go     <= (state == IDLE) && accept;
            rf_finish <= ((state == RUN) && accept && bus.s_last) || (state == SINGLE);
            if (accept) begin
                rf_data_in <= bus.s_data;
            end
        end
    end

    // Error flag spans every cycle from go through WAIT of the packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
            count_sat  <= 1'b0;
            err_seen   <= 1'b0;
        end else if ((state == IDLE) && accept) begin
            beat_count <= COUNT_ONE;
            count_sat  <= 1'b0;
            err_seen   <= 1'b0;
        end else begin
            if ((state == RUN) && accept) begin
                if (beat_count == COUNT_MAX) begin
                    count_sat <= 1'b1;
                end else begin
                    beat_count <= beat_count + COUNT_ONE;
                end
            end
            if (state != IDLE) begin
                err_seen <= err_seen || rf_debug_error;
            end
        end
    end

    range_result_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_result (
        .clock     (clock),
        .reset     (reset),
        .capture   (capture),
        .cap_range (rf_range),
        .cap_count (beat_count),
        .cap_sat   (count_sat),
        .cap_error (cap_error),
        .res_ready (bus.res_ready),
        .res_range (bus.res_range),
        .res_count (bus.res_count),
        .res_sat   (bus.res_sat),
        .res_error (bus.res_error),
        .res_valid (bus.res_valid)
    );

endmodule

// File: tb/tb_range_sequencer.sv
// Testbench for range_sequencer driving a behavioural RangeFinder model; results
// are predicted per packet into a scoreboard and compared at each handshake.
module tb_range_sequencer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    typedef struct {
        logic [WIDTH-1:0] rng;
        logic [CNT_W-1:0] count;
        logic             sat;
        logic             err;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] rf_data_in;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range;
    logic             rf_debug_error;

    logic             rf_running;
    logic             rf_err_q;
    logic             inject_err;
    logic [WIDTH-1:0] rf_max;
    logic [WIDTH-1:0] rf_min;

    int               vectors = 0;
    int               miscompares = 0;
    int               cyc = 0;
    int               go_cnt = 0;
    int               fin_cnt = 0;
    int               both_cnt = 0;
    int               go_cyc = 0;
    int               fin_cyc = 0;
    exp_t             sb_q[$];
    logic [WIDTH-1:0] beat_vals[0:299];

    always #5 clock = ~clock;

    range_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    range_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus.slave),
        .rf_data_in     (rf_data_in),
        .rf_go          (rf_go),
        .rf_finish      (rf_finish),
        .rf_range       (rf_range),
        .rf_debug_error (rf_debug_error)
    );

    // RangeFinder stand-in: tracks max/min from go through finish inclusive.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_running <= 1'b0;
            rf_err_q   <= 1'b0;
            rf_max     <= '0;
            rf_min     <= '0;
        end else if (rf_go && rf_finish) begin
            rf_err_q   <= 1'b1;
            rf_running <= 1'b0;
        end else if (rf_go) begin
            rf_err_q   <= rf_running;
            rf_running <= 1'b1;
            rf_max     <= rf_data_in;
            rf_min     <= rf_data_in;
        end else if (rf_running) begin
            if (rf_data_in > rf_max) rf_max <= rf_data_in;
            if (rf_data_in < rf_min) rf_min <= rf_data_in;
            if (rf_finish) rf_running <= 1'b0;
        end else if (rf_finish) begin
            rf_err_q <= 1'b1;
        end
    end

    assign rf_range       = rf_max - rf_min;
    assign rf_debug_error = rf_err_q || inject_err;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (rf_go) begin
            go_cnt++;
            go_cyc = cyc;
        end
        if (rf_finish) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        if (rf_go && rf_finish) both_cnt++;
    end

    // Scoreboard: every completed handshake must match the oldest prediction.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("res_range", bus.res_range, e.rng);
                checkOutput("res_count", bus.res_count, e.count);
                checkOutput("res_sat",   bus.res_sat,   e.sat);
                checkOutput("res_error", bus.res_error, e.err);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pushExpected(input int n, input logic err);
        exp_t             e;
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] mn;
        mx = beat_vals[0];
        mn = beat_vals[0];
        for (int i = 1; i < n; i++) begin
            if (beat_vals[i] > mx) mx = beat_vals[i];
            if (beat_vals[i] < mn) mn = beat_vals[i];
        end
        e.rng   = mx - mn;
        e.count = (n > 255) ? 8'd255 : 8'(n);
        e.sat   = (n > 255);
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic waitAccept(input string tag);
        int budget = 0;
        @(negedge clock);
        while (!bus.s_ready && budget < 50) begin
            budget++;
            @(negedge clock);
        end
        if (!bus.s_ready) checkOutput(tag, 32'd0, 32'd1);
        tick();
    endtask

    task automatic applyStimulus(input int n, input int gap_after, input int gap_len, input logic err_inject);
        pushExpected(n, err_inject);
        for (int i = 0; i < n; i++) begin
            if (gap_len > 0 && i == gap_after) begin
                bus.s_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    inject_err = err_inject && (g == 0);
                    @(negedge clock);
                    checkOutput("rf_data_hold", rf_data_in, beat_vals[gap_after-1]);
                    tick();
                end
                inject_err = 1'b0;
            end
            bus.s_valid = 1'b1;
            bus.s_data  = beat_vals[i];
            bus.s_last  = (i == n - 1);
            waitAccept("accept_timeout");
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (sb_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("result_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic measureLatency(input string tag, input int exp_edges);
        int edges = 0;
        while (!bus.res_valid && edges < 20) begin
            tick();
            edges++;
        end
        checkOutput(tag, edges, exp_edges);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g0;
        int f0;
        logic seen_valid;

        reset         = 1'b1;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.res_ready = 1'b1;
        inject_err    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_s_ready",    bus.s_ready,   32'd0);
        checkOutput("rst_rf_go",      rf_go,         32'd0);
        checkOutput("rst_rf_finish",  rf_finish,     32'd0);
        checkOutput("rst_rf_data_in", rf_data_in,    32'd0);
        checkOutput("rst_res_valid",  bus.res_valid, 32'd0);
        checkOutput("rst_res_range",  bus.res_range, 32'd0);
        checkOutput("rst_res_count",  bus.res_count, 32'd0);
        checkOutput("rst_res_sat",    bus.res_sat,   32'd0);
        checkOutput("rst_res_error",  bus.res_error, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] back-to-back packet 5,9,2,7");
        beat_vals[0] = 16'd5; beat_vals[1] = 16'd9; beat_vals[2] = 16'd2; beat_vals[3] = 16'd7;
        g0 = go_cnt; f0 = fin_cnt;
        applyStimulus(4, 0, 0, 1'b0);
        measureLatency("latency_multi", 2);
        waitDrain();
        checkOutput("go_pulses",  go_cnt - g0,  32'd1);
        checkOutput("fin_pulses", fin_cnt - f0, 32'd1);

        $display("[TB] same packet with 3 idle cycles mid-packet");
        g0 = go_cnt; f0 = fin_cnt;
        applyStimulus(4, 2, 3, 1'b0);
        waitDrain();
        checkOutput("gap_go_pulses",  go_cnt - g0,  32'd1);
        checkOutput("gap_fin_pulses", fin_cnt - f0, 32'd1);

        $display("[TB] single beat 0x1234");
        beat_vals[0] = 16'h1234;
        g0 = go_cnt; f0 = fin_cnt;
        applyStimulus(1, 0, 0, 1'b0);
        measureLatency("latency_single", 3);
        waitDrain();
        checkOutput("single_go_pulses",  go_cnt - g0,  32'd1);
        checkOutput("single_fin_pulses", fin_cnt - f0, 32'd1);
        checkOutput("single_go_to_fin",  fin_cyc - go_cyc, 32'd1);

        $display("[TB] debug_error raised mid-packet");
        beat_vals[0] = 16'd1; beat_vals[1] = 16'd2; beat_vals[2] = 16'd3;
        applyStimulus(3, 1, 2, 1'b1);
        waitDrain();

        $display("[TB] back-pressure on result slot");
        bus.res_ready = 1'b0;
        beat_vals[0] = 16'd5; beat_vals[1] = 16'd9; beat_vals[2] = 16'd2; beat_vals[3] = 16'd7;
        applyStimulus(4, 0, 0, 1'b0);
        measureLatency("latency_backpressure", 2);
        beat_vals[0] = 16'd3; beat_vals[1] = 16'd8;
        pushExpected(2, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd3;
        bus.s_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("bp_s_ready",   bus.s_ready,   32'd0);
            checkOutput("bp_res_valid", bus.res_valid, 32'd1);
            checkOutput("bp_res_range", bus.res_range, 32'd7);
            checkOutput("bp_res_count", bus.res_count, 32'd4);
            tick();
        end
        bus.res_ready = 1'b1;
        @(negedge clock);
        checkOutput("bp_release_s_ready", bus.s_ready, 32'd1);
        tick();
        bus.s_data = 16'd8;
        bus.s_last = 1'b1;
        waitAccept("bp_accept_timeout");
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        waitDrain();

        $display("[TB] 300-beat saturating packet");
        for (int i = 0; i < 300; i++) beat_vals[i] = 16'(10 + i);
        applyStimulus(300, 0, 0, 1'b0);
        waitDrain();

        $display("[TB] reset during RUN");
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd4;
        bus.s_last  = 1'b0;
        waitAccept("rst_accept0_timeout");
        bus.s_data = 16'd6;
        waitAccept("rst_accept1_timeout");
        bus.s_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_rf_go",      rf_go,         32'd0);
        checkOutput("midrst_rf_finish",  rf_finish,     32'd0);
        checkOutput("midrst_rf_data_in", rf_data_in,    32'd0);
        checkOutput("midrst_res_valid",  bus.res_valid, 32'd0);
        checkOutput("midrst_s_ready",    bus.s_ready,   32'd0);
        checkOutput("midrst_res_count",  bus.res_count, 32'd0);
        tick();
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            seen_valid = seen_valid | bus.res_valid;
            tick();
        end
        checkOutput("midrst_no_result", seen_valid, 32'd0);
        beat_vals[0] = 16'd3; beat_vals[1] = 16'd8;
        applyStimulus(2, 0, 0, 1'b0);
        waitDrain();

        checkOutput("go_finish_overlap", both_cnt, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
